sc_inst_loader: RTL and testbench

- Encodes a stream of symbolic instruction commands (mnemonic index plus register, shift, immediate and target fields) into 32-bit MIPS words.
- Writes the words sequentially into instruction memory.
- It is the encoding counterpart of the single-cycle control unit's decoder and produces exactly the op/func patterns that the decoder recognises.
- Used to load test programs into the sc_cpu_io instruction memory while the CPU is held idle.

---
 rtl/sc_inst_loader.sv | 155 +++++++++++++++
 tb/tb_sc_inst_loader.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_inst_loader.sv
// sc_inst_loader: encodes symbolic MIPS commands into 32-bit words and
// streams them into instruction memory, one word per clock, starting at
// word address 0. Produces exactly the op/func patterns the single-cycle
// decoder recognises.
module sc_inst_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [4:0]        cmd_kind,
    input  logic [4:0]        cmd_rs,
    input  logic [4:0]        cmd_rt,
    input  logic [4:0]        cmd_rd,
    input  logic [4:0]        cmd_sa,
    input  logic [15:0]       cmd_imm,
    input  logic [25:0]       cmd_target,
    input  logic              cmd_last,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

    typedef struct packed {
        logic [4:0]  kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sa;
        logic [15:0] imm;
        logic [25:0] target;
        logic        last;
    } cmd_t;

    state_t      state, state_nx;
    cmd_t        cmd;
    logic [31:0] enc_word;
    logic        enc_legal;
    logic        accept;
    logic        restart;
    logic        last_acc;   // cmd_last has been accepted in this load

    assign cmd = '{kind: cmd_kind, rs: cmd_rs, rt: cmd_rt, rd: cmd_rd,
                   sa: cmd_sa, imm: cmd_imm, target: cmd_target, last: cmd_last};

    function automatic logic [31:0] r_word(input logic [5:0] func, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [4:0] sa);
        return {6'b000000, rs, rt, rd, sa, func};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Combinational encoder: mnemonic index to instruction word, forcing unused fields to 0
    always_comb begin
        enc_word  = 32'd0;
        enc_legal = 1'b1;
        case (cmd.kind)
            5'd0:  enc_word = r_word(6'b100000, cmd.rs, cmd.rt, cmd.rd, 5'd0);
            5'd1:  enc_word = r_word(6'b100010, cmd.rs, cmd.rt, cmd.rd, 5'd0);
            5'd2:  enc_word = r_word(6'b100100, cmd.rs, cmd.rt, cmd.rd, 5'd0);
            5'd3:  enc_word = r_word(6'b100101, cmd.rs, cmd.rt, cmd.rd, 5'd0);
            5'd4:  enc_word = r_word(6'b100110, cmd.rs, cmd.rt, cmd.rd, 5'd0);
            5'd5:  enc_word = r_word(6'b000000, 5'd0, cmd.rt, cmd.rd, cmd.sa);
            5'd6:  enc_word = r_word(6'b000010, 5'd0, cmd.rt, cmd.rd, cmd.sa);
            5'd7:  enc_word = r_word(6'b000011, 5'd0, cmd.rt, cmd.rd, cmd.sa);
            5'd8:  enc_word = r_word(6'b001000, cmd.rs, 5'd0, 5'd0, 5'd0);
            5'd9:  enc_word = r_word(6'b110000, cmd.rs, cmd.rt, cmd.rd, 5'd0);
            5'd10: enc_word = i_word(6'b001000, cmd.rs, cmd.rt, cmd.imm);
            5'd11: enc_word = i_word(6'b001100, cmd.rs, cmd.rt, cmd.imm);
            5'd12: enc_word = i_word(6'b001101, cmd.rs, cmd.rt, cmd.imm);
            5'd13: enc_word = i_word(6'b001110, cmd.rs, cmd.rt, cmd.imm);
            5'd14: enc_word = i_word(6'b100011, cmd.rs, cmd.rt, cmd.imm);
            5'd15: enc_word = i_word(6'b101011, cmd.rs, cmd.rt, cmd.imm);
            5'd16: enc_word = i_word(6'b000100, cmd.rs, cmd.rt, cmd.imm);
            5'd17: enc_word = i_word(6'b000101, cmd.rs, cmd.rt, cmd.imm);
            5'd18: enc_word = i_word(6'b001111, 5'd0, cmd.rt, cmd.imm);
            5'd19: enc_word = {6'b000010, cmd.target};
            5'd20: enc_word = {6'b000011, cmd.target};
            default: enc_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // Next state and handshake/status outputs. Readiness drops while the top
    // address is being written so the pointer can never wrap.
    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        restart   = 1'b0;
        busy      = (state == RUN) || im_we;
        done      = (state == DONE);
        err       = (state == ERR);
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_nx = RUN;
                    restart  = 1'b1;
                end
            end
            RUN: begin
                cmd_ready = !last_acc && !(im_we && im_addr == TOP_ADDR);
                accept    = cmd_valid && cmd_ready;
                if (im_we && last_acc)                  state_nx = DONE;
                else if (im_we && im_addr == TOP_ADDR)  state_nx = ERR;
                else if (accept && !enc_legal)          state_nx = ERR;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Write register: an accepted legal command is presented to memory on the
    // following cycle, with pointer and count advancing at the same edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= 32'd0;
            count    <= '0;
            last_acc <= 1'b0;
        end else begin
            im_we <= 1'b0;
            if (restart) begin
                im_addr  <= '0;
                count    <= '0;
                last_acc <= 1'b0;
            end else if (accept && enc_legal) begin
                im_we    <= 1'b1;
                im_addr  <= count[ADDR_W-1:0];
                im_wdata <= enc_word;
                count    <= count + 1'b1;
                last_acc <= cmd.last;
            end
        end
    end
endmodule

// File: tb/tb_sc_inst_loader.sv
// Bench for sc_inst_loader: two instances (64-word and 4-word memories)
// share one command bus; 'sel' routes start/cmd_valid to one of them.
// Expected writes come from a program-level reference model and are queued
// when a program is issued; a negedge monitor pops them on every im_we.
module tb_sc_inst_loader;
    logic clock = 1'b0;
    logic resetn = 1'b1;
    logic start = 1'b0;
    logic cmd_valid = 1'b0;
    logic sel = 1'b0;
    logic [4:0]  cmd_kind = '0, cmd_rs = '0, cmd_rt = '0, cmd_rd = '0, cmd_sa = '0;
    logic [15:0] cmd_imm = '0;
    logic [25:0] cmd_target = '0;
    logic        cmd_last = 1'b0;

    logic start6, valid6, start2, valid2;
    logic r6, we6, busy6, done6, err6;
    logic [5:0] addr6;
    logic [31:0] data6;
    logic [6:0] cnt6;
    logic r2, we2, busy2, done2, err2;
    logic [1:0] addr2;
    logic [31:0] data2;
    logic [2:0] cnt2;

    assign start6 = start & ~sel;
    assign valid6 = cmd_valid & ~sel;
    assign start2 = start & sel;
    assign valid2 = cmd_valid & sel;

    always #5 clock = ~clock;

    sc_inst_loader #(.ADDR_W(6)) u6 (
        .clock(clock), .resetn(resetn), .start(start6), .cmd_valid(valid6), .cmd_ready(r6),
        .cmd_kind(cmd_kind), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_sa(cmd_sa),
        .cmd_imm(cmd_imm), .cmd_target(cmd_target), .cmd_last(cmd_last),
        .im_we(we6), .im_addr(addr6), .im_wdata(data6), .busy(busy6), .done(done6),
        .err(err6), .count(cnt6));

    sc_inst_loader #(.ADDR_W(2)) u2 (
        .clock(clock), .resetn(resetn), .start(start2), .cmd_valid(valid2), .cmd_ready(r2),
        .cmd_kind(cmd_kind), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_sa(cmd_sa),
        .cmd_imm(cmd_imm), .cmd_target(cmd_target), .cmd_last(cmd_last),
        .im_we(we2), .im_addr(addr2), .im_wdata(data2), .busy(busy2), .done(done2),
        .err(err2), .count(cnt2));

    // Selected-instance view
    logic rdy_s, busy_s, done_s, err_s;
    int   cnt_s;
    always_comb begin
        if (sel) begin
            rdy_s = r2; busy_s = busy2; done_s = done2; err_s = err2; cnt_s = int'(cnt2);
        end else begin
            rdy_s = r6; busy_s = busy6; done_s = done6; err_s = err6; cnt_s = int'(cnt6);
        end
    end

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;
    wr_t expq[$];

    int checks = 0;
    int failures = 0;

    // Program under test
    int          p_n;
    logic [4:0]  p_kind [0:99];
    logic [4:0]  p_rs [0:99], p_rt [0:99], p_rd [0:99], p_sa [0:99];
    logic [15:0] p_imm [0:99];
    logic [25:0] p_tgt [0:99];
    logic        p_last [0:99];
    logic [31:0] lit [0:7];

    logic [5:0] func_t [0:9];
    logic [5:0] op_t [0:10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference encoder: build the full field layout, then blank the fields
    // each mnemonic does not use.
    function automatic logic [31:0] ref_enc(input int i);
        logic [31:0] w;
        int k;
        k = int'(p_kind[i]);
        w = 32'd0;
        if (k <= 9) begin
            w = {6'd0, p_rs[i], p_rt[i], p_rd[i], p_sa[i], func_t[k]};
            if (k >= 5 && k <= 7) w[25:21] = 5'd0;
            else if (k == 8)      w[20:6]  = 15'd0;
            else                  w[10:6]  = 5'd0;
        end else if (k <= 18) begin
            w = {op_t[k-10], p_rs[i], p_rt[i], p_imm[i]};
            if (k == 18) w[25:21] = 5'd0;
        end else if (k == 19) begin
            w = {6'b000010, p_tgt[i]};
        end else if (k == 20) begin
            w = {6'b000011, p_tgt[i]};
        end
        return w;
    endfunction

    // Program-level model: which commands are taken, what gets written, how the load ends
    task automatic model_push(input int depth, input bit use_lit, output int n_acc,
                              output bit e_done, output bit e_err, output int e_cnt);
        wr_t e;
        int w;
        w = 0; n_acc = 0; e_done = 0; e_err = 0;
        for (int i = 0; i < p_n; i++) begin
            n_acc++;
            if (p_kind[i] > 5'd20) begin e_err = 1; break; end
            e.addr = w;
            e.data = use_lit ? lit[w] : ref_enc(i);
            expq.push_back(e);
            w++;
            if (p_last[i]) begin e_done = 1; break; end
            if (w == depth) begin e_err = 1; break; end
        end
        e_cnt = w;
    endtask

    task automatic mon_write(input int a, input logic [31:0] d);
        wr_t e;
        if (expq.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_write actual_addr=%0d actual_data=%08h expected=none", a, d);
        end else begin
            e = expq.pop_front();
            chk("wr_addr", a, e.addr);
            chk("wr_data", d, e.data);
        end
    endtask

    // Monitor: every write strobe from either instance must match the next expected word
    always @(negedge clock) begin
        if (we6) mon_write(int'(addr6), data6);
        if (we2) mon_write(int'(addr2), data2);
    end

    task automatic set_full(input int i, input int k, input int rs, input int rt, input int rd,
                            input int sa, input int imm, input int tgt, input bit last);
        p_kind[i] = 5'(k); p_rs[i] = 5'(rs); p_rt[i] = 5'(rt); p_rd[i] = 5'(rd);
        p_sa[i] = 5'(sa); p_imm[i] = 16'(imm); p_tgt[i] = 26'(tgt); p_last[i] = last;
    endtask

    task automatic set_rand(input int i, input int k, input bit last);
        set_full(i, k, int'($urandom), int'($urandom), int'($urandom), int'($urandom),
                 int'($urandom), int'($urandom), last);
    endtask

    task automatic load(input int i);
        cmd_kind = p_kind[i]; cmd_rs = p_rs[i]; cmd_rt = p_rt[i]; cmd_rd = p_rd[i];
        cmd_sa = p_sa[i]; cmd_imm = p_imm[i]; cmd_target = p_tgt[i]; cmd_last = p_last[i];
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we6"}, we6, 0);     chk({tag, "_addr6"}, addr6, 0);
        chk({tag, "_data6"}, data6, 0); chk({tag, "_cnt6"}, cnt6, 0);
        chk({tag, "_done6"}, done6, 0); chk({tag, "_err6"}, err6, 0);
        chk({tag, "_rdy6"}, r6, 0);     chk({tag, "_busy6"}, busy6, 0);
        chk({tag, "_we2"}, we2, 0);     chk({tag, "_cnt2"}, cnt2, 0);
    endtask

    // Issue the current program to the selected instance and check how the load ends
    task automatic run_prog(input int depth, input bit pre_valid, input bit gaps, input bit use_lit);
        int n_acc, e_cnt, idx, idle, stall, acc;
        bit e_done, e_err, first;
        model_push(depth, use_lit, n_acc, e_done, e_err, e_cnt);
        idx = 0; idle = 0; stall = 0; acc = 0; first = 1;
        @(posedge clock); #1;
        load(0);
        if (pre_valid) begin
            cmd_valid = 1'b1;
            repeat (3) begin
                @(negedge clock);
                chk("ready_before_start", rdy_s, 0);
            end
            @(posedge clock); #1;
        end
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        cmd_valid = 1'b1;
        while (idx < p_n && idle < 8) begin
            @(negedge clock);
            if (first && !gaps) chk("first_accept_after_start", rdy_s, 1);
            first = 0;
            if (cmd_valid && rdy_s) begin
                idx++; acc++; idle = 0;
            end else begin
                idle++;
                if (cmd_valid && acc < n_acc) stall++;
            end
            @(posedge clock); #1;
            if (idx < p_n) begin
                load(idx);
                cmd_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("accepted_cmds", acc, n_acc);
        if (!gaps) chk("stall_cycles", stall, 0);
        chk("done", done_s, e_done);
        chk("err", err_s, e_err);
        chk("count", cnt_s, e_cnt);
        chk("ready_after_end", rdy_s, 0);
        chk("busy_after_end", busy_s, 0);
        chk("writes_outstanding", expq.size(), 0);
        expq.delete();
    endtask

    task automatic rand_prog(input int n, input bit force_last);
        int k;
        p_n = n;
        for (int i = 0; i < n; i++) begin
            k = ($urandom_range(0, 11) == 0) ? int'($urandom_range(21, 31)) : int'($urandom_range(0, 20));
            set_rand(i, k, (i == n - 1) ? force_last : ($urandom_range(0, 9) == 0));
        end
    endtask

    initial begin
        func_t[0] = 6'h20; func_t[1] = 6'h22; func_t[2] = 6'h24; func_t[3] = 6'h25;
        func_t[4] = 6'h26; func_t[5] = 6'h00; func_t[6] = 6'h02; func_t[7] = 6'h03;
        func_t[8] = 6'h08; func_t[9] = 6'h30;
        op_t[0] = 6'h08; op_t[1] = 6'h0C; op_t[2] = 6'h0D; op_t[3] = 6'h0E; op_t[4] = 6'h23;
        op_t[5] = 6'h2B; op_t[6] = 6'h04; op_t[7] = 6'h05; op_t[8] = 6'h0F;
        op_t[9] = 6'h02; op_t[10] = 6'h03;

        #1 resetn = 1'b0;
        #2 check_reset_outputs("reset");
        #9 resetn = 1'b1;

        // Basic two-word program
        sel = 1'b0;
        p_n = 2;
        set_full(0, 0, 1, 2, 3, 9, 16'h1234, 26'h155, 1'b0);
        set_full(1, 10, 0, 1, 7, 3, 5, 26'h2AA, 1'b1);
        lit[0] = 32'h00221820; lit[1] = 32'h20010005;
        run_prog(64, 1'b0, 1'b0, 1'b1);

        // Encoding sweep with forced-zero fields
        p_n = 6;
        set_full(0, 5, 7, 2, 4, 3, 16'hBEEF, 26'h3FF, 1'b0);
        set_full(1, 9, 1, 2, 6, 5, 16'h1111, 26'h111, 1'b0);
        set_full(2, 14, 29, 5, 3, 7, 16'hFFFC, 26'h222, 1'b0);
        set_full(3, 15, 1, 2, 9, 9, 8, 26'h333, 1'b0);
        set_full(4, 16, 1, 2, 31, 31, 16'hFFFF, 26'h444, 1'b0);
        set_full(5, 20, 13, 14, 15, 16, 16'h5555, 26'h10, 1'b1);
        lit[0] = 32'h000220C0; lit[1] = 32'h00223030; lit[2] = 32'h8FA5FFFC;
        lit[3] = 32'hAC220008; lit[4] = 32'h1022FFFF; lit[5] = 32'h0C000010;
        run_prog(64, 1'b0, 1'b0, 1'b1);

        // cmd_valid held through IDLE before start
        p_n = 5;
        for (int i = 0; i < 5; i++) set_rand(i, int'($urandom_range(0, 20)), i == 4);
        run_prog(64, 1'b1, 1'b0, 1'b0);

        // Illegal kind as the second command
        p_n = 3;
        set_rand(0, 3, 1'b0);
        set_rand(1, 25, 1'b0);
        set_rand(2, 12, 1'b1);
        run_prog(64, 1'b0, 1'b0, 1'b0);

        // 4-word memory: overflow, then a last command exactly at the top address
        sel = 1'b1;
        p_n = 5;
        for (int i = 0; i < 5; i++) set_rand(i, int'($urandom_range(0, 20)), 1'b0);
        run_prog(4, 1'b0, 1'b0, 1'b0);
        p_n = 4;
        for (int i = 0; i < 4; i++) set_rand(i, int'($urandom_range(0, 20)), i == 3);
        run_prog(4, 1'b0, 1'b0, 1'b0);

        // 64-word memory overflow
        sel = 1'b0;
        p_n = 65;
        for (int i = 0; i < 65; i++) set_rand(i, int'($urandom_range(0, 20)), 1'b0);
        run_prog(64, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset while a write is on the bus, then reload
        p_n = 6;
        for (int i = 0; i < 6; i++) set_rand(i, int'($urandom_range(0, 20)), i == 5);
        begin
            int n_acc, e_cnt;
            bit e_done, e_err;
            model_push(64, 1'b0, n_acc, e_done, e_err, e_cnt);
        end
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0; load(0); cmd_valid = 1'b1;
        @(posedge clock); #1 load(1);
        @(posedge clock); #1;
        chk("pre_reset_we", we6, 1);
        chk("pre_reset_addr", addr6, 1);
        #1 resetn = 1'b0; cmd_valid = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clock);
        expq.delete();
        @(posedge clock); #1 resetn = 1'b1;
        rand_prog(4, 1'b1);
        for (int i = 0; i < 4; i++) if (p_kind[i] > 5'd20) p_kind[i] = 5'd1;
        run_prog(64, 1'b0, 1'b0, 1'b0);

        // Random programs on both instances
        for (int t = 0; t < 24; t++) begin
            int n;
            sel = 1'($urandom_range(0, 1));
            n = sel ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 10));
            rand_prog(n, (sel && n >= 5) ? 1'($urandom_range(0, 1)) : 1'b1);
            run_prog(sel ? 4 : 64, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (4) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
